// File: rtl/bus_initiator_if.sv
// bus_initiator_if
//   Groups the core-side request/response handshake and the CPU bus control
//   signals of the bus initiator.
//   Core side : req_valid/req_ready, req_we, req_iom, req_addr[19:0],
//               req_wdata[7:0]; rsp_valid, rsp_rdata[7:0], rsp_err.
//   Bus side  : ALE, Address[19:0], IOM, CS, RD (active-low), WR (active-low),
//               READY.
//   The bidirectional Data bus is a plain inout port on the initiator so that
//   tristate resolution stays at module boundaries.
//   master : view used by the initiator.
//   slave  : view used by the core/responder side (drives requests and READY).
interface bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_iom;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        ALE;
    logic [19:0] Address;
    logic        IOM;
    logic        CS;
    logic        RD;
    logic        WR;
    logic        READY;

    modport master (
        input  req_valid, req_we, req_iom, req_addr, req_wdata, READY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ALE, Address, IOM, CS, RD, WR
    );

    modport slave (
        output req_valid, req_we, req_iom, req_addr, req_wdata, READY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ALE, Address, IOM, CS, RD, WR
    );
endinterface

// File: rtl/bus_initiator.sv
// bus_initiator
//   Bus-master end of the 8-bit data / 20-bit address CPU bus. Takes single
//   read/write requests from the core, runs T1-T2-T3-(TW)*-T4 bus cycles and
//   returns a one-cycle response pulse with read data or a timeout error.
//   Parameters : MAX_WAIT  - wait states tolerated before timeout (1..255)
//                IO_ADDR_W - I/O address width; upper address bits are zeroed
//                            for I/O-space cycles
//   Ports      : CLK, RESET (synchronous, active-high)
//                bus  - bus_initiator_if.master (request, response, strobes)
//                Data - 8-bit bidirectional bus data, driven only while a
//                       write is in T2..T4
module bus_initiator #(
    parameter int MAX_WAIT  = 15,
    parameter int IO_ADDR_W = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    bus_initiator_if.master bus,
    inout  wire  [7:0]      Data
);
    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } state_t;

    localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [19:0] IO_MASK    = 20'((64'd1 << IO_ADDR_W) - 64'd1);

    state_t     state;
    logic       we_q;
    logic [7:0] wdata_q;
    logic       data_oe;
    logic [7:0] wait_cnt;

    // I/O-space cycles only carry the low IO_ADDR_W address bits.
    function automatic logic [19:0] bus_addr(input logic iom, input logic [19:0] addr);
        return iom ? addr : (addr & IO_MASK);
    endfunction

    // RESET gates req_ready directly so no request is offered while in reset.
    assign bus.req_ready = (state == IDLE) && !RESET;
    assign Data          = data_oe ? wdata_q : 8'hzz;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            bus.ALE       <= 1'b0;
            bus.CS        <= 1'b0;
            bus.RD        <= 1'b1;
            bus.WR        <= 1'b1;
            bus.IOM       <= 1'b1;
            bus.Address   <= '0;
            data_oe       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state)
                // Accept: latch the request and present address for T1.
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        wdata_q     <= bus.req_wdata;
                        bus.IOM     <= bus.req_iom;
                        bus.Address <= bus_addr(bus.req_iom, bus.req_addr);
                        bus.ALE     <= 1'b1;
                        bus.CS      <= 1'b1;
                        bus.rsp_err <= 1'b0;
                        state       <= T1;
                    end
                end
                // T1 -> T2: drop ALE, assert the strobe, start driving writes.
                T1: begin
                    bus.ALE <= 1'b0;
                    bus.RD  <= we_q;
                    bus.WR  <= !we_q;
                    data_oe <= we_q;
                    state   <= T2;
                end
                T2: begin
                    state <= T3;
                end
                // T3/TW: READY ends the cycle; otherwise count wait states
                // until the timeout bound forces T4 with an error.
                T3, TW: begin
                    if (bus.READY || (state == TW && wait_cnt == MAX_WAIT_C)) begin
                        bus.RD        <= 1'b1;
                        bus.WR        <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= T4;
                        if (!bus.READY) begin
                            bus.rsp_rdata <= 8'hFF;
                            bus.rsp_err   <= 1'b1;
                        end else if (!we_q) begin
                            bus.rsp_rdata <= Data;
                        end
                    end else begin
                        state    <= TW;
                        wait_cnt <= (state == T3) ? 8'd1 : wait_cnt + 8'd1;
                    end
                end
                // T4 -> IDLE: end of cycle, release CS and the data bus.
                T4: begin
                    bus.CS  <= 1'b0;
                    data_oe <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator
//   Randomized bench for bus_initiator. A driver issues requests and plays the
//   responder (READY wait states, read data); every accepted request pushes its
//   expected response into a scoreboard queue that an independent monitor pops
//   whenever rsp_valid is seen. Bus phases are checked cycle by cycle.
module tb_bus_initiator;
    localparam int MAX_WAIT  = 15;
    localparam int IO_ADDR_W = 16;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         due;
    } exp_t;

    logic       CLK;
    logic       RESET;
    wire  [7:0] Data;
    logic [7:0] plan_rd;
    logic       probe_en;
    logic [7:0] last_rd;
    int         cyc;
    int         errors;
    int         checks;
    exp_t       sbq[$];

    bus_initiator_if bus ();

    bus_initiator #(
        .MAX_WAIT  (MAX_WAIT),
        .IO_ADDR_W (IO_ADDR_W)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master),
        .Data  (Data)
    );

    // Responder returns plan_rd while the read strobe is low; probe_en lets the
    // bench drive a marker to prove the initiator has released the bus.
    assign Data = probe_en ? 8'h3C : (bus.RD ? 8'hzz : plan_rd);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: protocol invariants every cycle, responses against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        chk("strobe_protocol",
            ((!bus.RD && !bus.WR) || (bus.ALE && (!bus.RD || !bus.WR))) ? 1'b1 : 1'b0, 1'b0);
        if (bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: actual=rsp_valid required=none (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rd);
                chk("rsp_err", bus.rsp_err, e.err);
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk(nm, {bus.ALE, bus.CS, bus.RD, bus.WR, bus.IOM, bus.Address,
                 bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready},
                {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'h0, 1'b0, 8'h00, 1'b0, 1'b0});
    endtask

    // One transaction; w = number of cycles READY is held low from T3 on.
    // Called and returns at a negedge with the initiator idle.
    task automatic do_txn(input logic we, input logic iom, input logic [19:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd, input int w);
        int          weff;
        int          n;
        int          guard;
        bit          to;
        bit          strobe;
        logic [19:0] ea;
        exp_t        e;
        to   = (w > MAX_WAIT);
        weff = to ? MAX_WAIT : w;
        ea   = iom ? addr : 20'(addr % (1 << IO_ADDR_W));

        plan_rd       = rd;
        bus.req_we    = we;
        bus.req_iom   = iom;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready) begin
            @(negedge CLK);
            guard++;
            if (guard > 50) begin
                chk("accept_timeout", 1'b0, 1'b1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        n = cyc + 1;
        e.rd  = to ? 8'hFF : (we ? last_rd : rd);
        e.err = to;
        e.due = n + 3 + weff;
        last_rd = e.rd;
        sbq.push_back(e);
        bus.READY = 1'($urandom_range(0, 1));

        for (int p = 0; p <= 4 + weff; p++) begin
            @(negedge CLK);
            if (p <= 3 + weff) begin
                strobe = (p >= 1) && (p <= 2 + weff);
                chk("bus_phase",
                    {bus.ALE, bus.CS, bus.RD, bus.WR, bus.IOM, bus.Address, bus.req_ready},
                    {(p == 0), 1'b1, !(strobe && !we), !(strobe && we), iom, ea, 1'b0});
                if (we && p >= 1) chk("write_data", Data, wd);
                // Busy: random requests must be ignored.
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_we    = 1'($urandom_range(0, 1));
                bus.req_iom   = 1'($urandom_range(0, 1));
                bus.req_addr  = 20'($urandom);
                bus.req_wdata = 8'($urandom);
            end else begin
                chk("idle_phase", {bus.ALE, bus.CS, bus.RD, bus.WR, bus.req_ready},
                    {1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
                bus.req_valid = 1'b0;
            end
            // READY for the upcoming edge (edge index p+1 after acceptance).
            if (p + 1 >= 3 && p + 1 < 3 + w) bus.READY = 1'b0;
            else if (p + 1 == 3 + weff && !to) bus.READY = 1'b1;
            else bus.READY = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic reset_mid_write();
        bus.req_we    = 1'b1;
        bus.req_iom   = 1'b1;
        bus.req_addr  = 20'h12345;
        bus.req_wdata = 8'hA5;
        bus.req_valid = 1'b1;
        @(negedge CLK);
        bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("pre_reset_write", {bus.WR, Data}, {1'b0, 8'hA5});
        RESET = 1'b1;
        @(negedge CLK);
        chk_reset_vals("reset_mid_t2");
        probe_en = 1'b1;
        #1;
        chk("data_released", Data, 8'h3C);
        probe_en = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        last_rd = 8'h00;
        #1;
        chk("ready_after_reset", bus.req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        last_rd       = 8'h00;
        plan_rd       = 8'h00;
        probe_en      = 1'b0;
        RESET         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_iom   = 1'b1;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.READY     = 1'b1;

        repeat (3) @(negedge CLK);
        chk_reset_vals("reset_initial");
        RESET = 1'b0;
        #1;
        chk("ready_after_init", bus.req_ready, 1'b1);

        do_txn(1'b1, 1'b1, 20'hABCDE, 8'h5A, 8'h00, 0);
        do_txn(1'b0, 1'b1, 20'h00010, 8'h00, 8'hC3, 0);
        do_txn(1'b0, 1'b0, 20'hF1234, 8'h00, 8'h77, 0);
        do_txn(1'b0, 1'b1, 20'h2468A, 8'h00, 8'h9E, 3);
        do_txn(1'b0, 1'b1, 20'h13579, 8'h00, 8'h11, 40);
        do_txn(1'b1, 1'b0, 20'h5A5A5, 8'h66, 8'h00, 0);
        do_txn(1'b0, 1'b1, 20'h0BEEF, 8'h00, 8'hD2, MAX_WAIT);
        do_txn(1'b1, 1'b1, 20'h00FFF, 8'h99, 8'h00, MAX_WAIT + 1);
        reset_mid_write();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4))
                                           : int'($urandom_range(14, 20));
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom),
                   8'($urandom), 8'($urandom), w);
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_initiator.md
# bus_initiator

Bus-master end of the 8-bit-data / 20-bit-address CPU bus served by the memory/IO responder. Accepts single read/write requests from the core-side request port, sequences T1–T4 bus cycles (ALE, active-low RD/WR, IOM, CS), and returns read data or write completion on a one-cycle response pulse. It inserts wait states while READY is low and aborts with an error flag after a bounded wait.

## Interface
- MAX_WAIT, 15: maximum wait states (TW) before timeout; range 1–255.
- IO_ADDR_W, 16: I/O address width; Address[19:IO_ADDR_W] forced 0 when IOM=0.
- CLK  in  1  bus clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  initiator can accept a request; high only in IDLE.
- req_we  in  1  1=write, 0=read.
- req_iom  in  1  1=memory space, 0=I/O space.
- req_addr  in  20  byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid on reads.
- rsp_err  out  1  wait-state timeout; valid with rsp_valid.
- ALE  out  1  address latch enable, active-high.
- Address  out  20  bus address.
- IOM  out  1  1=memory, 0=I/O.
- CS  out  1  cycle-in-progress chip select, active-high.
- RD  out  1  read strobe, active-low.
- WR  out  1  write strobe, active-low.
- Data  inout  8  bus data; driven only during write T2–T4, else 'z.
- READY  in  1  responder ready; low inserts wait states.

## Operation
- All bus outputs registered; states one-hot: IDLE, T1, T2, T3, TW, T4.
- IDLE: req_ready=1. On req_valid at posedge, capture we/iom/addr/wdata; go T1.
- T1: ALE=1, CS=1, Address/IOM driven from captured request; RD=WR=1.
- T2: ALE=0; RD=0 (read) or WR=0 (write); write drives Data=wdata.
- T3: strobe held. READY=1 at end of T3 → T4; READY=0 → TW, wait_cnt=1.
- TW: strobe held. READY=1 → T4; else if wait_cnt==MAX_WAIT → T4 with timeout; else wait_cnt+1.
- Read data captured from Data on the edge leaving T3/TW into rsp_rdata; on timeout rsp_rdata=8'hFF, rsp_err=1.
- T4: RD=WR=1, CS=1, write data still driven (hold); rsp_valid=1 for this cycle; next state IDLE.
- Address, IOM held stable T1 through T4; I/O cycles zero Address[19:IO_ADDR_W].
- Requests while not in IDLE are not accepted (req_ready=0); core must hold req_valid.

## Timing
- Reset values: ALE=0, CS=0, RD=1, WR=1, IOM=1, Address=0, Data='z, req_ready=0 while RESET=1 and 1 the cycle after, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait_cnt=0.
- Zero-wait transaction accepted at edge N: T1 at N+1, T2 N+2, T3 N+3, T4 N+4 (rsp_valid), IDLE N+5; next accept earliest at edge N+5. Throughput one transaction per 5 cycles.
- Each wait state adds exactly one cycle; timeout transaction lasts 5+MAX_WAIT cycles.
- READY ignored outside T3/TW.
- RESET asserted in any state: next edge returns to IDLE with reset values; in-flight transaction dropped, no rsp_valid, Data released same edge.
- rsp_err cleared on every new acceptance; rsp_rdata holds last value between responses.
- Never RD=0 and WR=0 simultaneously; ALE never high while a strobe is low.

## Test plan
- Reset: RESET=1 for 3 cycles mid-T2 of a write → outputs at reset values next edge, WR=1, Data='z, no rsp_valid.
- Memory write addr=20'hABCDE, wdata=8'h5A, READY=1 → ALE only in T1, WR=0 in T2–T3, Data=8'h5A T2–T4, rsp_valid at N+4, rsp_err=0.
- Memory read addr=20'h00010 with responder returning 8'hC3 → RD=0 T2–T3, rsp_rdata=8'hC3 with rsp_valid at N+4.
- I/O read req_iom=0, addr=20'hF1234 → IOM=0, Address=20'h01234 T1–T4.
- Wait states: READY low for 3 cycles from T3 → 3 TW cycles, rsp_valid at N+7, rsp_err=0, data sampled on READY=1 edge.
- Timeout: READY held low, MAX_WAIT=15 → rsp_valid at N+19, rsp_err=1, rsp_rdata=8'hFF; following request accepted normally with rsp_err=0.
